// File: rtl/mm_seq_ctrl.sv
// Sequencer for the NxN systolic multiply array: walks a beat counter per job and
// decodes it into operand reads, skewed row clears and per-row result strobes.
module mm_seq_ctrl #(
    parameter int KW        = 5,
    parameter int N         = 8,
    parameter int DRAIN_LAT = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic [3:0]    conf_in,
    output logic [3:0]    conf,
    output logic          busy,
    output logic          done,
    input  logic          opnd_ready,
    input  logic          out_ready,
    output logic          rd_en,
    output logic [KW-1:0] rd_addr,
    output logic          feed_zero,
    output logic          arr_en,
    output logic [N-1:0]  arr_clear,
    output logic [N-1:0]  z_valid,
    output logic [2:0]    z_idx
);

    localparam int BW = KW + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    typedef struct packed {
        logic          rd_en;
        logic [KW-1:0] rd_addr;
        logic          feed_zero;
        logic [N-1:0]  clr;
        logic [N-1:0]  zv;
        logic [2:0]    zi;
    } beat_t;

    // Array-facing outputs for beat b of a job with length k.
    function automatic beat_t decode(input logic [BW-1:0] b, input logic [KW-1:0] k);
        beat_t         o;
        logic [BW-1:0] kb;
        logic [BW-1:0] z0;
        o  = '0;
        kb = {2'b00, k};
        z0 = kb + BW'(DRAIN_LAT + 1);
        o.rd_en = (b < kb);
        if (o.rd_en) begin
            o.rd_addr = b[KW-1:0];
        end
        o.feed_zero = (b == '0) || (b > kb);
        for (int i = 0; i < N; i++) begin
            o.clr[i] = (b == BW'(i + 1)) || (b == kb + BW'(i + 1));
            o.zv[i]  = (b >= z0 + BW'(i)) && (b <= z0 + BW'(i + N - 1));
        end
        if (o.zv[0]) begin
            o.zi = 3'(b - z0);
        end
        return o;
    endfunction

    state_t        state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    beat_t         beat_q, beat_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0]    conf_q, conf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          stall;
    logic [BW-1:0] b_end;

    // Final beat is the last result beat of lane N-1, so no z beat is cut off.
    assign b_end = {2'b00, k_q} + BW'(2 * N + DRAIN_LAT - 1);

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        beat_d  = beat_q;
        k_d     = k_q;
        conf_d  = conf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        stall   = (beat_q.rd_en && !opnd_ready) || ((|beat_q.zv) && !out_ready);
        arr_en  = (state_q == S_RUN) && !stall;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d    = k_len;
                    conf_d = conf_in;
                    b_d    = '0;
                    if (k_len != '0) begin
                        state_d = S_RUN;
                        beat_d  = decode('0, k_len);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (arr_en) begin
                    if (b_q == b_end) begin
                        state_d = S_FIN;
                        beat_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        b_d    = b_q + BW'(1);
                        beat_d = decode(b_q + BW'(1), k_q);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                b_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            beat_q  <= '0;
            k_q     <= '0;
            conf_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            beat_q  <= beat_d;
            k_q     <= k_d;
            conf_q  <= conf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign conf      = conf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = beat_q.rd_en;
    assign rd_addr   = beat_q.rd_addr;
    assign feed_zero = beat_q.feed_zero;
    assign arr_clear = beat_q.clr;
    assign z_valid   = beat_q.zv;
    assign z_idx     = beat_q.zi;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Randomized bench for mm_seq_ctrl: a beat-level job model predicts every output each
// cycle; per-job latency, result-beat counts and reset behaviour are checked on top.
module tb_mm_seq_ctrl;

    localparam int KW = 5;
    localparam int N  = 8;
    localparam int DL = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] k_len;
    logic [3:0]    conf_in;
    logic [3:0]    conf;
    logic          busy, done;
    logic          opnd_ready, out_ready;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic          feed_zero, arr_en;
    logic [N-1:0]  arr_clear, z_valid;
    logic [2:0]    z_idx;

    mm_seq_ctrl #(.KW(KW), .N(N), .DRAIN_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .conf_in(conf_in),
        .conf(conf), .busy(busy), .done(done), .opnd_ready(opnd_ready),
        .out_ready(out_ready), .rd_en(rd_en), .rd_addr(rd_addr), .feed_zero(feed_zero),
        .arr_en(arr_en), .arr_clear(arr_clear), .z_valid(z_valid), .z_idx(z_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Job model: 0 idle, 1 running, 2 finishing
    int         m_state = 0;
    int         m_b     = 0;
    int         m_k     = 0;
    logic [3:0] m_conf  = '0;
    logic       m_en;
    int         cyc;
    int         zc [N];
    int         act_seen;
    int         done_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d, b=%0d)", tag, got, exp, cyc, m_b);
        end
    endtask

    task automatic check_outputs();
        logic          run, e_rden, e_fz, e_stall;
        logic [KW-1:0] e_addr;
        logic [N-1:0]  e_clr, e_zv;
        logic [2:0]    e_zi;
        run    = (m_state == 1);
        e_rden = run && (m_b < m_k);
        e_addr = e_rden ? KW'(m_b) : '0;
        e_fz   = run && (m_b == 0 || m_b > m_k);
        for (int i = 0; i < N; i++) begin
            e_clr[i] = run && (m_b == 1 + i || m_b == m_k + 1 + i);
            e_zv[i]  = run && (m_b >= m_k + 1 + i + DL) && (m_b <= m_k + i + DL + N);
        end
        e_zi    = e_zv[0] ? 3'(m_b - (m_k + 1 + DL)) : 3'd0;
        e_stall = (e_rden && !opnd_ready) || ((|e_zv) && !out_ready);
        m_en    = run && !e_stall;
        check("arr_en", 32'(arr_en), 32'(m_en));
        check("rd", 32'({rd_en, rd_addr}), 32'({e_rden, e_addr}));
        check("feed_zero", 32'(feed_zero), 32'(e_fz));
        check("arr_clear", 32'(arr_clear), 32'(e_clr));
        check("z_valid", 32'(z_valid), 32'(e_zv));
        check("z_idx", 32'(z_idx), 32'(e_zi));
        check("busy", 32'(busy), 32'(run));
        check("done", 32'(done), 32'(m_state == 2));
        check("conf", 32'(conf), 32'(m_conf));
        if (arr_en) begin
            for (int i = 0; i < N; i++) begin
                if (z_valid[i]) zc[i]++;
            end
        end
        if (arr_en || rd_en) act_seen++;
        if (done) done_cyc = cyc;
    endtask

    task automatic model_step();
        case (m_state)
            0: if (start) begin
                m_k     = int'(k_len);
                m_conf  = conf_in;
                m_b     = 0;
                m_state = (k_len != '0) ? 1 : 2;
            end
            1: if (m_en) begin
                if (m_b == m_k + 2 * N + DL - 1) m_state = 2;
                else m_b++;
            end
            default: begin
                m_state = 0;
                m_b     = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({busy, done, rd_en, rd_addr, feed_zero, arr_en}), 32'd0);
        check({tag, "_clr"}, 32'(arr_clear), 32'd0);
        check({tag, "_zv"}, 32'({z_valid, z_idx}), 32'd0);
        check({tag, "_conf"}, 32'(conf), 32'd0);
    endtask

    // mode 0: ready tied high; 1: random ready; 2: opnd stall 2 cycles at b=2;
    // 3: out stall 3 cycles at b=20. Random start pulses while busy in every mode.
    task automatic run_job(input int k, input int mode);
        int stalls;
        stalls   = 0;
        zc       = '{default: 0};
        act_seen = 0;
        done_cyc = -1;
        cyc      = 0;
        start    = 1'b1;
        k_len    = KW'(k);
        conf_in  = 4'($urandom);
        opnd_ready = 1'b1;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        while (m_state != 0 && cyc < 600) begin
            opnd_ready = 1'b1;
            out_ready  = 1'b1;
            case (mode)
                1: begin
                    opnd_ready = ($urandom_range(0, 3) != 0);
                    out_ready  = ($urandom_range(0, 3) != 0);
                end
                2: if (m_state == 1 && m_b == 2 && stalls < 2) begin
                    opnd_ready = 1'b0;
                    stalls++;
                end
                3: if (m_state == 1 && m_b == 20 && stalls < 3) begin
                    out_ready = 1'b0;
                    stalls++;
                end
                default: ;
            endcase
            start   = ($urandom_range(0, 5) == 0);
            k_len   = KW'($urandom);
            conf_in = 4'($urandom);
            tick();
        end
        start = 1'b0;
        check("job_timeout", 32'(m_state), 32'd0);
        if (k == 0) begin
            check("k0_activity", 32'(act_seen), 32'd0);
            check("k0_done_cyc", 32'(done_cyc), 32'd1);
        end else begin
            for (int i = 0; i < N; i++) check("z_beats", 32'(zc[i]), 32'(N));
            if (mode != 1) check("latency", 32'(done_cyc), 32'(k + 2 * N + DL + 1 + stalls));
        end
        $display("job K=%0d mode=%0d done at cycle %0d", k, mode, done_cyc);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        k_len      = '0;
        conf_in    = '0;
        opnd_ready = 1'b1;
        out_ready  = 1'b1;
        cyc        = 0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_job(8, 0);
        run_job(3, 0);
        run_job(8, 2);
        run_job(8, 3);
        run_job(0, 0);
        run_job(31, 0);
        run_job(1, 0);
        for (int j = 0; j < 12; j++) run_job(int'($urandom_range(0, 31)), 1);

        // Abort a running job with reset at b=10, then run a clean job
        cyc     = 0;
        start   = 1'b1;
        k_len   = KW'(8);
        conf_in = 4'hA;
        tick();
        start = 1'b0;
        while (!(m_state == 1 && m_b == 10) && cyc < 100) tick();
        check("reach_b10", 32'(m_b), 32'd10);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_state = 0;
        m_b     = 0;
        m_k     = 0;
        m_conf  = '0;
        $display("reset applied mid-job at b=10");
        run_job(4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
